elevator_scheduler: RTL and testbench

- Sequencing controller for the elevator car: latches floor requests, picks travel direction with SCAN (keep direction while requests lie ahead), drives the motor and door outputs, and times travel and door dwell.
- Sits above the request-latch flip-flops and drives the car/door datapath.
- Floor position is tracked internally; there is no position sensor.

---
 rtl/elevator_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_scheduler
//  Description : Elevator car sequencing controller. Latches floor requests,
//                picks the travel direction with SCAN (keep going while
//                requests lie ahead), times one-floor travel and door dwell,
//                and drives registered motor/door outputs. Floor position is
//                tracked internally by counting completed travel intervals.
//  Ports       : clock      - system clock, rising edge
//                reset      - asynchronous active-low reset
//                req_btn    - merged hall/car request buttons (level)
//                door_block - door obstruction, holds the doors open
//                floor      - current floor index
//                motor_up   - car moving up
//                motor_down - car moving down
//                door_open  - doors open
//                pending    - latched outstanding requests
//                dir_up     - direction preference (1 = up)
//                busy       - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_scheduler #(
    parameter int N_FLOORS      = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] req_btn,
    input  logic                door_block,
    output logic [FLOOR_W-1:0]  floor,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up,
    output logic                busy
);

    localparam int TRAV_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [TRAV_W-1:0]  TRAV_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(N_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);

    // One-hot state encoding; anything else is illegal and recovers to IDLE.
    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_UP   = 4'b0010;
    localparam logic [3:0] S_DOWN = 4'b0100;
    localparam logic [3:0] S_DOOR = 4'b1000;

    logic [3:0]          state_q,      state_d;
    logic [FLOOR_W-1:0]  floor_q,      floor_d;
    logic [N_FLOORS-1:0] pending_q,    pending_d;
    logic                dir_up_q,     dir_up_d;
    logic [TRAV_W-1:0]   travel_cnt_q, travel_cnt_d;
    logic [DOOR_W-1:0]   door_cnt_q,   door_cnt_d;
    logic                motor_up_q,   motor_up_d;
    logic                motor_down_q, motor_down_d;
    logic                door_open_q,  door_open_d;
    logic                busy_q,       busy_d;

    // Any request strictly above floor f.
    function automatic logic any_above(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]  f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(f)) r = r | p[i];
        end
        return r;
    endfunction

    // Any request strictly below floor f.
    function automatic logic any_below(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]  f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i < int'(f)) r = r | p[i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            floor_q      <= '0;
            pending_q    <= '0;
            dir_up_q     <= 1'b1;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            pending_q    <= pending_d;
            dir_up_q     <= dir_up_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        logic                w_above;
        logic                w_below;
        logic                w_hold;
        logic                w_arrive;
        logic [FLOOR_W-1:0]  w_nf;

        state_d      = state_q;
        floor_d      = floor_q;
        dir_up_d     = dir_up_q;
        travel_cnt_d = travel_cnt_q + TRAV_W'(1);
        door_cnt_d   = '0;
        w_nf         = floor_q;

        // Direction decisions use registered requests only; a button seen
        // this edge influences the next decision.
        w_above  = any_above(pending_q, floor_q);
        w_below  = any_below(pending_q, floor_q);
        w_hold   = door_block | req_btn[floor_q];
        w_arrive = (travel_cnt_q == TRAV_LAST);

        case (state_q)
            S_IDLE: begin
                travel_cnt_d = '0;
                if (pending_q[floor_q]) begin
                    state_d = S_DOOR;
                end else if (w_above && (dir_up_q || !w_below)) begin
                    state_d  = S_UP;
                    dir_up_d = 1'b1;
                end else if (w_below) begin
                    state_d  = S_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            S_UP: begin
                if (floor_q == FLOOR_TOP) begin
                    state_d      = S_IDLE;
                    travel_cnt_d = '0;
                end else if (w_arrive) begin
                    w_nf         = floor_q + FLOOR_ONE;
                    floor_d      = w_nf;
                    travel_cnt_d = '0;
                    if (pending_q[w_nf])                  state_d = S_DOOR;
                    else if (!any_above(pending_q, w_nf)) state_d = S_IDLE;
                end
            end
            S_DOWN: begin
                if (floor_q == '0) begin
                    state_d      = S_IDLE;
                    travel_cnt_d = '0;
                end else if (w_arrive) begin
                    w_nf         = floor_q - FLOOR_ONE;
                    floor_d      = w_nf;
                    travel_cnt_d = '0;
                    if (pending_q[w_nf])                  state_d = S_DOOR;
                    else if (!any_below(pending_q, w_nf)) state_d = S_IDLE;
                end
            end
            S_DOOR: begin
                travel_cnt_d = '0;
                if (w_hold) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    door_cnt_d = door_cnt_q + DOOR_W'(1);
                end
            end
            default: begin
                state_d      = S_IDLE;
                travel_cnt_d = '0;
            end
        endcase

        // The floor being served (now, or from this edge on) never keeps a
        // request: pressing its button only extends the dwell.
        pending_d = pending_q | req_btn;
        if ((state_q == S_DOOR) || (state_d == S_DOOR)) begin
            pending_d[floor_d] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered from the next state)
    // ------------------------------------------------------------------
    always_comb begin
        motor_up_d   = (state_d == S_UP);
        motor_down_d = (state_d == S_DOWN);
        door_open_d  = (state_d == S_DOOR);
        busy_d       = (state_d != S_IDLE);
    end

    assign floor      = floor_q;
    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign door_open  = door_open_q;
    assign pending    = pending_q;
    assign dir_up     = dir_up_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_scheduler
//  Description : Directed self-checking bench for elevator_scheduler with
//                hand-computed expected values (edge-accurate timing).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

    localparam int N_FLOORS = 4;
    localparam int FLOOR_W  = 2;

    logic                clock;
    logic                reset;
    logic [N_FLOORS-1:0] req_btn;
    logic                door_block;
    logic [FLOOR_W-1:0]  floor;
    logic                motor_up;
    logic                motor_down;
    logic                door_open;
    logic [N_FLOORS-1:0] pending;
    logic                dir_up;
    logic                busy;

    int n_checks;
    int n_errors;

    elevator_scheduler #(
        .N_FLOORS      (N_FLOORS),
        .FLOOR_W       (FLOOR_W),
        .TRAVEL_CYCLES (8),
        .DOOR_CYCLES   (16)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_btn    (req_btn),
        .door_block (door_block),
        .floor      (floor),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .pending    (pending),
        .dir_up     (dir_up),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int door_cnt;
        int motor_cnt;
        int guard;

        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        req_btn    = '0;
        door_block = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        check_eq("rst_floor",   floor,      0);
        check_eq("rst_pending", pending,    0);
        check_eq("rst_dir_up",  dir_up,     1);
        check_eq("rst_outputs", {motor_up, motor_down, door_open, busy}, 0);

        // ---------------- single request to floor 2 ----------------
        reset   = 1'b1;
        req_btn = 4'b0100;
        tick(1);                                   // E0
        req_btn = '0;
        check_eq("t1_pending_E0", pending, 4'b0100);
        check_eq("t1_busy_E0",    busy,    0);
        tick(1);                                   // E1
        check_eq("t1_motor_up_E1", motor_up, 1);
        tick(8);                                   // E9
        check_eq("t1_floor_E9", floor,    1);
        check_eq("t1_up_E9",    motor_up, 1);
        tick(8);                                   // E17
        check_eq("t1_floor_E17",   floor,     2);
        check_eq("t1_door_E17",    door_open, 1);
        check_eq("t1_up_E17",      motor_up,  0);
        check_eq("t1_pending_E17", pending,   0);
        tick(15);                                  // E32
        check_eq("t1_door_E32", door_open, 1);
        tick(1);                                   // E33
        check_eq("t1_door_E33", door_open, 0);
        check_eq("t1_busy_E33", busy,      0);

        // ---------------- request at current floor (2) ----------------
        req_btn = 4'b0100;
        tick(1);
        req_btn = '0;
        check_eq("t2_pending_latch", pending,   4'b0100);
        check_eq("t2_door_latch",    door_open, 0);
        tick(1);
        check_eq("t2_door_open", door_open, 1);
        check_eq("t2_pending",   pending,   0);
        check_eq("t2_motors",    {motor_up, motor_down}, 0);
        tick(15);
        check_eq("t2_door_last", door_open, 1);
        tick(1);
        check_eq("t2_door_closed", door_open, 0);

        // ---------------- SCAN: at floor 2, dir up, pending {0,3} -------
        req_btn = 4'b1001;
        tick(1);                                   // F0
        req_btn = '0;
        check_eq("t3_pending", pending, 4'b1001);
        tick(1);                                   // F1
        check_eq("t3_goes_up", {motor_up, motor_down}, 2'b10);
        tick(8);                                   // F9
        check_eq("t3_floor3",      floor,     3);
        check_eq("t3_door3",       door_open, 1);
        check_eq("t3_pending_F9",  pending,   4'b0001);
        motor_cnt = 0;
        for (int k = 0; k < 16; k++) begin         // F10..F25
            tick(1);
            if (motor_down || motor_up) motor_cnt++;
        end
        check_eq("t3_no_motor_dwell", motor_cnt, 0);
        check_eq("t3_door_closed",    door_open, 0);
        tick(1);                                   // F26
        check_eq("t3_motor_down", motor_down, 1);
        check_eq("t3_dir_up",     dir_up,     0);
        tick(24);                                  // F50
        check_eq("t3_floor0",   floor,     0);
        check_eq("t3_door0",    door_open, 1);
        check_eq("t3_pending0", pending,   0);
        tick(16);
        check_eq("t3_idle", busy, 0);

        // ---------------- pass-through stop, 0 -> 3 with 2 added --------
        req_btn = 4'b1000;
        tick(1);                                   // G0
        req_btn = '0;
        tick(1);                                   // G1
        check_eq("t4_up", motor_up, 1);
        tick(10);                                  // G11
        check_eq("t4_floor1", floor, 1);
        req_btn = 4'b0100;
        tick(1);                                   // G12
        req_btn = '0;
        check_eq("t4_pending", pending, 4'b1100);
        tick(5);                                   // G17
        check_eq("t4_stop_floor", floor,     2);
        check_eq("t4_stop_door",  door_open, 1);
        check_eq("t4_stop_motor", motor_up,  0);
        check_eq("t4_stop_pend",  pending,   4'b1000);
        tick(16);                                  // G33
        check_eq("t4_door_closed", door_open, 0);
        tick(1);                                   // G34
        check_eq("t4_resume_up", motor_up, 1);
        tick(8);                                   // G42
        check_eq("t4_floor3", floor,     3);
        check_eq("t4_door3",  door_open, 1);
        tick(16);                                  // G58
        check_eq("t4_idle", busy, 0);

        // ---------------- door hold at floor 3 ----------------
        req_btn = 4'b1000;
        tick(1);                                   // H0
        req_btn = '0;
        tick(1);                                   // H1
        check_eq("t5_door_open", door_open, 1);
        door_cnt   = 1;
        motor_cnt  = 0;
        door_block = 1'b1;
        for (int k = 0; k < 40; k++) begin         // H2..H41
            tick(1);
            if (door_open) door_cnt++;
            if (motor_up || motor_down) motor_cnt++;
        end
        door_block = 1'b0;
        guard = 0;
        while (door_open && guard < 100) begin
            tick(1);
            guard++;
            if (door_open) door_cnt++;
            if (motor_up || motor_down) motor_cnt++;
        end
        check_eq("t5_no_timeout",  guard < 100, 1);
        check_eq("t5_door_cycles", door_cnt,    56);
        check_eq("t5_no_motor",    motor_cnt,   0);

        // ---------------- async reset mid-travel ----------------
        req_btn = 4'b0001;
        tick(1);
        req_btn = '0;
        tick(1);
        check_eq("t6_down", motor_down, 1);
        tick(10);
        check_eq("t6_floor2", floor,      2);
        check_eq("t6_moving", motor_down, 1);
        #3;
        reset = 1'b0;
        #1;
        check_eq("t6_rst_outputs", {motor_up, motor_down, door_open, busy}, 0);
        check_eq("t6_rst_floor",   floor,   0);
        check_eq("t6_rst_pending", pending, 0);
        check_eq("t6_rst_dir",     dir_up,  1);
        req_btn = 4'b1111;
        tick(2);
        check_eq("t6_held_pending", pending, 0);
        req_btn = '0;
        reset   = 1'b1;
        tick(4);
        check_eq("t6_idle_after", {motor_up, motor_down, door_open, busy}, 0);
        check_eq("t6_floor_after", floor, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
